multicycle_control_fsm: RTL and testbench

- Multi-cycle main controller for the 16-bit CPU.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives ALUOp into ALUControl and generates the datapath mux/write enables.
- Stalls on a memory-ready handshake and flags illegal opcodes and memory timeouts.

---
 rtl/multicycle_control_fsm.sv | 210 +++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle main controller for the 16-bit CPU.
// Sequences FETCH/DECODE/EXEC/MEM/WB; outputs decode from state, latched opcode and live inputs.
module multicycle_control_fsm #(
  parameter int WAIT_LIMIT = 15
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] OPCode,
  input  logic       Zero,
  input  logic       MemReady,
  output logic [1:0] ALUOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemToReg,
  output logic       InstrDone,
  output logic       IllegalOp,
  output logic       MemTimeout,
  output logic [2:0] State
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  localparam logic [3:0] OP_RLOG = 4'b0000;
  localparam logic [3:0] OP_RARI = 4'b0001;
  localparam logic [3:0] OP_RSHF = 4'b0010;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_SUBI = 4'b0101;
  localparam logic [3:0] OP_LW   = 4'b0110;
  localparam logic [3:0] OP_SW   = 4'b0111;
  localparam logic [3:0] OP_BEQ  = 4'b1000;
  localparam logic [3:0] OP_BNE  = 4'b1001;
  localparam logic [3:0] OP_J    = 4'b1010;
  localparam logic [3:0] OP_SLTI = 4'b1011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_SLT   = 2'b11;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_TWO    = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [7:0] WAIT_LIM = 8'(WAIT_LIMIT);

  state_t     state_reg, state_next;
  logic [3:0] op_reg, op_next;
  logic [7:0] wait_cnt_reg, wait_cnt_next;
  logic       timeout_reg, timeout_next;
  logic       waiting;

  function automatic logic is_rtype(input logic [3:0] op);
    return (op == OP_RLOG) || (op == OP_RARI) || (op == OP_RSHF);
  endfunction

  function automatic logic is_legal(input logic [3:0] op);
    return is_rtype(op) || ((op >= OP_ADDI) && (op <= OP_SLTI));
  endfunction

  // Only FETCH and MEM wait on memory; any other state (or a completed access) clears the count.
  always_comb begin
    waiting       = ((state_reg == ST_FETCH) || (state_reg == ST_MEM)) && !MemReady;
    wait_cnt_next = 8'd0;
    if (waiting) begin
      wait_cnt_next = (wait_cnt_reg == WAIT_LIM) ? WAIT_LIM : wait_cnt_reg + 8'd1;
    end
    timeout_next = timeout_reg || (wait_cnt_next == WAIT_LIM);
  end

  always_comb begin
    state_next = state_reg;
    op_next    = op_reg;
    ALUOp      = ALU_ADD;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_REG;
    PCSrc      = PC_ALU;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    RegDst     = 1'b0;
    MemToReg   = 1'b0;
    InstrDone  = 1'b0;
    IllegalOp  = 1'b0;

    case (state_reg)
      ST_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_TWO;
        IRWrite = MemReady;
        PCWrite = MemReady;
        if (MemReady) state_next = ST_DECODE;
      end

      ST_DECODE: begin
        op_next = OPCode;
        ALUSrcB = SRCB_IMM_SH;
        if (OPCode == OP_J) begin
          PCSrc      = PC_JUMP;
          PCWrite    = 1'b1;
          InstrDone  = 1'b1;
          state_next = ST_FETCH;
        end else if (!is_legal(OPCode)) begin
          IllegalOp  = 1'b1;
          state_next = ST_FETCH;
        end else begin
          state_next = ST_EXEC;
        end
      end

      ST_EXEC: begin
        ALUSrcA = 1'b1;
        case (op_reg)
          OP_RLOG, OP_RARI, OP_RSHF: begin
            ALUSrcB    = SRCB_REG;
            ALUOp      = ALU_FUNCT;
            state_next = ST_WB;
          end
          OP_ADDI: begin
            ALUSrcB    = SRCB_IMM;
            state_next = ST_WB;
          end
          OP_LW, OP_SW: begin
            ALUSrcB    = SRCB_IMM;
            state_next = ST_MEM;
          end
          OP_SUBI: begin
            ALUSrcB    = SRCB_IMM;
            ALUOp      = ALU_SUB;
            state_next = ST_WB;
          end
          OP_SLTI: begin
            ALUSrcB    = SRCB_IMM;
            ALUOp      = ALU_SLT;
            state_next = ST_WB;
          end
          OP_BEQ, OP_BNE: begin
            ALUSrcB    = SRCB_REG;
            ALUOp      = ALU_SUB;
            PCSrc      = PC_BRANCH;
            PCWrite    = (op_reg == OP_BEQ) ? Zero : !Zero;
            InstrDone  = 1'b1;
            state_next = ST_FETCH;
          end
          default: state_next = ST_FETCH;
        endcase
      end

      ST_MEM: begin
        MemRead  = (op_reg == OP_LW);
        MemWrite = (op_reg == OP_SW);
        if (MemReady) begin
          if (op_reg == OP_LW) begin
            state_next = ST_WB;
          end else begin
            InstrDone  = 1'b1;
            state_next = ST_FETCH;
          end
        end
      end

      ST_WB: begin
        RegWrite   = 1'b1;
        MemToReg   = (op_reg == OP_LW);
        RegDst     = is_rtype(op_reg);
        InstrDone  = 1'b1;
        state_next = ST_FETCH;
      end

      default: state_next = ST_FETCH;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg    <= ST_FETCH;
      op_reg       <= 4'd0;
      wait_cnt_reg <= 8'd0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      op_reg       <= op_next;
      wait_cnt_reg <= wait_cnt_next;
      timeout_reg  <= timeout_next;
    end
  end

  assign MemTimeout = timeout_reg;
  assign State      = state_reg;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench for multicycle_control_fsm: each instruction is expanded into its phase list
// and every cycle's outputs are compared against values derived from the opcode table.
module tb_multicycle_control_fsm;

  localparam int WAIT_LIMIT = 15;
  localparam int P_FETCH  = 0;
  localparam int P_DECODE = 1;
  localparam int P_EXEC   = 2;
  localparam int P_MEM    = 3;
  localparam int P_WB     = 4;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [3:0] OPCode;
  logic       Zero;
  logic       MemReady;
  logic [1:0] ALUOp;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSrc;
  logic       PCWrite, IRWrite, MemRead, MemWrite, RegWrite, RegDst, MemToReg;
  logic       InstrDone, IllegalOp, MemTimeout;
  logic [2:0] State;
  logic [18:0] got_vec;

  int vec_count        = 0;
  int miscompare_count = 0;
  int model_wait       = 0;
  bit model_timeout    = 1'b0;

  multicycle_control_fsm #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
    .Clock(Clock), .Reset(Reset), .OPCode(OPCode), .Zero(Zero), .MemReady(MemReady),
    .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .RegDst(RegDst), .MemToReg(MemToReg), .InstrDone(InstrDone),
    .IllegalOp(IllegalOp), .MemTimeout(MemTimeout), .State(State)
  );

  always #5 Clock = ~Clock;

  assign got_vec = {ALUOp, ALUSrcA, ALUSrcB, PCSrc, PCWrite, IRWrite, MemRead, MemWrite,
                    RegWrite, RegDst, MemToReg, InstrDone, IllegalOp, State};

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_count++;
    if (got !== exp) begin
      miscompare_count++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_rtype(input logic [3:0] op);
    return (op == 4'd0) || (op == 4'd1) || (op == 4'd2);
  endfunction

  function automatic bit is_legal(input logic [3:0] op);
    return is_rtype(op) || (op >= 4'd4 && op <= 4'd11);
  endfunction

  // Expected output word for one cycle of a phase, straight from the per-state output table.
  function automatic logic [18:0] expected_vec(input int phase, input logic [3:0] op,
                                               input bit zero, input bit mr);
    logic [1:0] aluop = 2'b00, srcb = 2'b00, pcsrc = 2'b00;
    bit srca = 0, pcw = 0, irw = 0, mrd = 0, mwr = 0, rw = 0, rdst = 0, m2r = 0, done = 0, ill = 0;
    bit branch = (op == 4'd8) || (op == 4'd9);
    case (phase)
      P_FETCH: begin
        mrd = 1; srcb = 2'b01; irw = mr; pcw = mr;
      end
      P_DECODE: begin
        srcb = 2'b11;
        if (op == 4'd10) begin pcsrc = 2'b10; pcw = 1; done = 1; end
        else if (!is_legal(op)) ill = 1;
      end
      P_EXEC: begin
        srca = 1;
        srcb = (is_rtype(op) || branch) ? 2'b00 : 2'b10;
        if (is_rtype(op)) aluop = 2'b10;
        else if (op == 4'd5 || branch) aluop = 2'b01;
        else if (op == 4'd11) aluop = 2'b11;
        if (branch) begin
          pcsrc = 2'b01;
          done  = 1;
          pcw   = (op == 4'd8) ? zero : !zero;
        end
      end
      P_MEM: begin
        mrd  = (op == 4'd6);
        mwr  = (op == 4'd7);
        done = (op == 4'd7) && mr;
      end
      default: begin
        rw = 1; m2r = (op == 4'd6); rdst = is_rtype(op); done = 1;
      end
    endcase
    return {aluop, srca, srcb, pcsrc, pcw, irw, mrd, mwr, rw, rdst, m2r, done, ill, 3'(phase)};
  endfunction

  // Waits < 0 means random MemReady; abort_mem >= 0 asserts Reset on that MEM cycle.
  task automatic run_instr(input int idx, input logic [3:0] op, input bit zero,
                           input int fetch_waits, input int mem_waits, input int abort_mem);
    int phases[$];
    int cycles = 0;
    if (is_legal(op) && op != 4'd10) begin
      phases = '{P_FETCH, P_DECODE, P_EXEC};
      if (op == 4'd6 || op == 4'd7) phases.push_back(P_MEM);
      if (op != 4'd7 && op != 4'd8 && op != 4'd9) phases.push_back(P_WB);
    end else begin
      phases = '{P_FETCH, P_DECODE};
    end
    foreach (phases[pi]) begin
      int p = phases[pi];
      bit waitable = (p == P_FETCH) || (p == P_MEM);
      int forced = (p == P_FETCH) ? fetch_waits : mem_waits;
      int k = 0;
      bit mr;
      do begin
        if (waitable) begin
          if (p == P_MEM && abort_mem >= 0 && k == abort_mem) begin
            Reset = 1'b1;
            MemReady = 1'b0;
            @(posedge Clock); #1;
            Reset = 1'b0;
            model_wait = 0;
            model_timeout = 1'b0;
            $display("instr %0d op=%b reset in MEM after %0d cycles", idx, op, cycles);
            return;
          end
          if (forced >= 0) mr = (k >= forced);
          else mr = (k >= 40) || ($urandom_range(0, 3) != 0);
        end else begin
          mr = 1'($urandom_range(0, 1));
        end
        OPCode   = (p == P_DECODE) ? op : 4'($urandom_range(0, 15));
        Zero     = (p == P_EXEC) ? zero : 1'($urandom_range(0, 1));
        MemReady = mr;
        @(negedge Clock);
        check_value($sformatf("i%0d op%b ph%0d cyc%0d outputs", idx, op, p, cycles),
                    32'(got_vec), 32'(expected_vec(p, op, zero, mr)));
        check_value($sformatf("i%0d op%b ph%0d cyc%0d MemTimeout", idx, op, p, cycles),
                    32'(MemTimeout), 32'(model_timeout));
        if (waitable && !mr) begin
          if (model_wait < WAIT_LIMIT) model_wait++;
          if (model_wait == WAIT_LIMIT) model_timeout = 1'b1;
        end else begin
          model_wait = 0;
        end
        @(posedge Clock); #1;
        cycles++;
        k++;
      end while (waitable && !mr);
    end
    $display("instr %0d op=%b zero=%0d cycles=%0d timeout=%0d", idx, op, zero, cycles, model_timeout);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx = 0;
    Reset = 1'b1; MemReady = 1'b0; OPCode = 4'd0; Zero = 1'b0;
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b0;

    run_instr(idx++, 4'b0001, 1'b0, 0, 0, -1);
    run_instr(idx++, 4'b0110, 1'b0, 0, 2, -1);
    run_instr(idx++, 4'b1000, 1'b1, 0, 0, -1);
    run_instr(idx++, 4'b1000, 1'b0, 0, 0, -1);
    run_instr(idx++, 4'b1001, 1'b1, 0, 0, -1);
    run_instr(idx++, 4'b1001, 1'b0, 0, 0, -1);
    run_instr(idx++, 4'b1010, 1'b0, 0, 0, -1);
    run_instr(idx++, 4'b1111, 1'b0, 0, 0, -1);
    run_instr(idx++, 4'b1011, 1'b0, 0, 0, -1);
    run_instr(idx++, 4'b0101, 1'b0, 0, 0, -1);
    run_instr(idx++, 4'b0111, 1'b0, 0, 0, -1);
    run_instr(idx++, 4'b0100, 1'b0, 20, 0, -1);
    run_instr(idx++, 4'b0010, 1'b0, 0, 0, -1);
    run_instr(idx++, 4'b0111, 1'b0, 0, 10, 2);
    run_instr(idx++, 4'b0000, 1'b0, 0, 0, -1);

    for (int i = 0; i < 300; i++) begin
      logic [3:0] op = 4'($urandom_range(0, 15));
      bit zero = 1'($urandom_range(0, 1));
      int fw = ($urandom_range(0, 24) == 0) ? int'($urandom_range(12, 20)) : -1;
      int mw = ($urandom_range(0, 24) == 0) ? int'($urandom_range(12, 20)) : -1;
      int ab = ($urandom_range(0, 29) == 0) ? int'($urandom_range(0, 2)) : -1;
      if (ab >= 0 && mw < 0) mw = 5;
      run_instr(idx++, op, zero, fw, mw, ab);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompare_count);
    $finish;
  end

endmodule
